// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction-fetch block and the control unit:
//   - FSM state encoding of instr_fetch
//   - 6-bit opcode constants (instr[31:26]) understood by the control decoder
// No ports (package).
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_HALT  = 3'd3,
        ST_ERR   = 3'd4
    } fetch_state_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_HALT  = 6'b111111;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/instr_fetch_pc_next.sv
// -----------------------------------------------------------------------------
// pc_next
// Purely combinational next-PC generator for the fetch unit.
//   pc            in  32  address of the instruction just accepted
//   branch_taken  in  1   select the redirect target instead of pc+4
//   branch_offset in  16  signed word offset, relative to pc+4
//   next_pc       out 32  pc+4, or pc+4+(sext(branch_offset)<<2); modulo 2^32
// -----------------------------------------------------------------------------
module pc_next (
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    output logic [31:0] next_pc
);

    logic signed [31:0] byte_offset;
    logic        [31:0] seq_pc;

    // Word offset sign-extended and scaled to bytes in one concatenation.
    assign byte_offset = {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign seq_pc      = pc + 32'd4;

    // 32-bit adds drop the carry, giving the required wrap-around.
    assign next_pc = branch_taken ? (seq_pc + $unsigned(byte_offset)) : seq_pc;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit: reads one word from instruction memory, presents it
// to the control decoder with a valid/ready handshake, then advances or
// redirects the PC. A consumed halt opcode parks the unit until reset.
//
// Parameters
//   RESET_PC     first fetch address after start
//   TIMEOUT_CYC  max FETCH cycles without imem_ack (FETCH_TIMEOUT_EN only)
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   start          in   pulse: begin fetching at RESET_PC (IDLE only)
//   imem_req       out  read request (asserted in FETCH)
//   imem_addr      out  32-bit byte address, equals pc
//   imem_ack       in   read data available this cycle
//   imem_rdata     in   32-bit read data
//   instr          out  registered instruction
//   opcode         out  instr[31:26]
//   instr_valid    out  instr/opcode valid (ISSUE state)
//   instr_ready    in   decoder accepts instr this cycle
//   branch_taken   in   redirect on accept
//   branch_offset  in   signed 16-bit word offset for redirect
//   pc             out  address of the instruction being fetched or held
//   halted         out  halt opcode consumed
//   fetch_err      out  memory timeout occurred
//
// Build option
//   FETCH_TIMEOUT_EN  when defined, a FETCH that waits TIMEOUT_CYC cycles
//                     without imem_ack moves to ERR and raises fetch_err.
//                     When undefined, FETCH waits indefinitely and
//                     fetch_err is tied low.
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    output logic [31:0] pc,
    output logic        halted,
    output logic        fetch_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_target;
    logic         accept;

    pc_next u_pc_next (
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .next_pc       (pc_target)
    );

    assign accept = (state_q == ST_ISSUE) && instr_ready;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Parameter kept in the interface for builds with the timeout enabled.
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

    // State, PC and instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_ISSUE;
                end
`ifdef FETCH_TIMEOUT_EN
                // The count holds the number of ack-less cycles already
                // spent, so the last permitted cycle ends in ERR.
                else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_ISSUE: begin
                if (accept) begin
                    if (opcode_of(instr_q) == OPC_HALT) begin
                        // Halt keeps pc on the halt instruction and ignores
                        // any redirect presented alongside it.
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = pc_target;
                        state_d = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and status outputs are decoded directly from state.
    assign imem_req    = (state_q == ST_FETCH);
    assign instr_valid = (state_q == ST_ISSUE);
    assign halted      = (state_q == ST_HALT);
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err   = (state_q == ST_ERR);
`else
    assign fetch_err   = 1'b0;
`endif

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign opcode    = opcode_of(instr_q);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic [31:0] pc;
    logic        halted;
    logic        fetch_err;

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .opcode        (opcode),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .pc            (pc),
        .halted        (halted),
        .fetch_err     (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; branch_taken = 1'b0; branch_offset = '0;
        tick(); tick();

        // Reset state
        check("rst_req",    32'(imem_req),    32'd0);
        check("rst_valid",  32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted),      32'd0);
        check("rst_err",    32'(fetch_err),   32'd0);
        check("rst_pc",     pc,               32'h0);
        check("rst_instr",  instr,            32'h0);
        check("rst_opcode", 32'(opcode),      32'd0);

        // Start -> FETCH at RESET_PC
        rst = 1'b0; start = 1'b1; tick(); start = 1'b0;
        check("f0_req",   32'(imem_req),    32'd1);
        check("f0_addr",  imem_addr,        32'h0);
        check("f0_valid", 32'(instr_valid), 32'd0);

        // Ack with zero wait states -> valid next cycle
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005; tick(); imem_ack = 1'b0;
        check("i0_valid",  32'(instr_valid), 32'd1);
        check("i0_instr",  instr,            32'h2008_0005);
        check("i0_opcode", 32'(opcode),      32'h08);
        check("i0_req",    32'(imem_req),    32'd0);

        // Stall for 5 cycles; stray ack and branch must be ignored
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        branch_taken = 1'b1; branch_offset = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_instr", instr,            32'h2008_0005);
            check("stall_req",   32'(imem_req),    32'd0);
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_pc",    pc,               32'h0);
        end
        imem_ack = 1'b0; branch_taken = 1'b0;

        // Accept -> pc+4, request again one cycle later
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        check("acc_pc",    pc,               32'h4);
        check("acc_req",   32'(imem_req),    32'd1);
        check("acc_valid", 32'(instr_valid), 32'd0);

        // start outside IDLE is ignored
        start = 1'b1; tick(); start = 1'b0;
        check("start_ign_pc",  pc,            32'h4);
        check("start_ign_req", 32'(imem_req), 32'd1);

        // Back-to-back: ack then accept with branch to 0x40 (4+4+14*4)
        imem_ack = 1'b1; imem_rdata = 32'h0000_0000; tick(); imem_ack = 1'b0;
        check("rtype_opcode", 32'(opcode), 32'd0);
        instr_ready = 1'b1; branch_taken = 1'b1; branch_offset = 16'h000E; tick();
        instr_ready = 1'b0; branch_taken = 1'b0;
        check("br_fwd_addr", imem_addr,     32'h40);
        check("br_fwd_req",  32'(imem_req), 32'd1);

        // Backward branch at 0x40 with offset -2 -> 0x3C
        imem_ack = 1'b1; imem_rdata = 32'h0800_0000; tick(); imem_ack = 1'b0;
        check("j_opcode", 32'(opcode), 32'h02);
        instr_ready = 1'b1; branch_taken = 1'b1; branch_offset = 16'hFFFE; tick();
        instr_ready = 1'b0; branch_taken = 1'b0;
        check("br_back_addr", imem_addr, 32'h3C);

        // Branch 0x3C + 4 - 0x44 -> 0xFFFF_FFFC, then +4 wraps to 0
        imem_ack = 1'b1; imem_rdata = 32'h0000_0000; tick(); imem_ack = 1'b0;
        instr_ready = 1'b1; branch_taken = 1'b1; branch_offset = 16'hFFEF; tick();
        instr_ready = 1'b0; branch_taken = 1'b0;
        check("br_top_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1; tick(); imem_ack = 1'b0;
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        check("wrap_addr", imem_addr, 32'h0);

        // Halt opcode accepted with a branch present -> HALT, pc kept
        imem_ack = 1'b1; imem_rdata = 32'hFC00_0000; tick(); imem_ack = 1'b0;
        check("halt_opcode", 32'(opcode), 32'h3F);
        instr_ready = 1'b1; branch_taken = 1'b1; branch_offset = 16'h0010; tick();
        instr_ready = 1'b0; branch_taken = 1'b0;
        check("halt_flag",  32'(halted),      32'd1);
        check("halt_pc",    pc,               32'h0);
        check("halt_req",   32'(imem_req),    32'd0);
        check("halt_valid", 32'(instr_valid), 32'd0);
        start = 1'b1; imem_ack = 1'b1; tick(); start = 1'b0; imem_ack = 1'b0;
        tick();
        check("halt_hold",     32'(halted),   32'd1);
        check("halt_hold_req", 32'(imem_req), 32'd0);

        // Reset leaves HALT
        rst = 1'b1; tick(); rst = 1'b0;
        check("unhalt_flag",  32'(halted),      32'd0);
        check("unhalt_valid", 32'(instr_valid), 32'd0);
        check("unhalt_instr", instr,            32'h0);
        check("unhalt_req",   32'(imem_req),    32'd0);

        // Reset in the same cycle as imem_ack
        start = 1'b1; tick(); start = 1'b0;
        instr_ready = 1'b1; branch_taken = 1'b1; branch_offset = 16'h0040;
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678; tick(); imem_ack = 1'b0;
        check("pre_rst_valid", 32'(instr_valid), 32'd1);
        // Reset in the same cycle as an accept
        rst = 1'b1; tick(); rst = 1'b0;
        instr_ready = 1'b0; branch_taken = 1'b0;
        check("rst_acc_pc",    pc,               32'h0);
        check("rst_acc_valid", 32'(instr_valid), 32'd0);
        check("rst_acc_req",   32'(imem_req),    32'd0);

        start = 1'b1; tick(); start = 1'b0;
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678; tick();
        rst = 1'b0; imem_ack = 1'b0;
        check("rst_ack_valid", 32'(instr_valid), 32'd0);
        check("rst_ack_pc",    pc,               32'h0);
        check("rst_ack_instr", instr,            32'h0);
        tick();
        check("rst_ack_idle",  32'(imem_req),    32'd0);

        // No ack for 100 cycles: default build never errors
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check("noto_err", 32'(fetch_err), 32'd0);
        check("noto_req", 32'(imem_req),  32'd1);
        check("noto_pc",  pc,             32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
